// File: rtl/rect_hit_scanner.sv
// Per-pixel topmost-rectangle resolver: one rect per cycle from a registered-read table.
// Latency N+2 cycles to resp_valid (1 when count=0); req_ready only in IDLE, holds result until resp_ready.

`ifndef COORD_WIDTH
`define COORD_WIDTH 16
`endif

module comparator #(
  parameter int WIDTH     = 16,
  parameter bit INCLUSIVE = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res
);
  assign res = INCLUSIVE ? (a <= b) : (a < b);
endmodule

module rect_hit_scanner #(
  parameter int COORD_WIDTH = `COORD_WIDTH,
  parameter int COLOR_WIDTH = 16,
  parameter int MAX_RECTS   = 64,
  parameter int ADDR_WIDTH  = $clog2(MAX_RECTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [COORD_WIDTH-1:0] req_x,
  input  logic [COORD_WIDTH-1:0] req_y,
  input  logic [ADDR_WIDTH:0]    rect_count,
  input  logic [COLOR_WIDTH-1:0] bg_color,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [COORD_WIDTH-1:0] rect_left,
  input  logic [COORD_WIDTH-1:0] rect_top,
  input  logic [COORD_WIDTH-1:0] rect_right,
  input  logic [COORD_WIDTH-1:0] rect_bottom,
  input  logic [COLOR_WIDTH-1:0] rect_color,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_hit,
  output logic [COLOR_WIDTH-1:0] resp_color,
  output logic [ADDR_WIDTH-1:0]  resp_index
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESP} state_t;

  localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(MAX_RECTS);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH:0]     cnt;
  logic [COORD_WIDTH-1:0]  px;
  logic [COORD_WIDTH-1:0]  py;
  logic                    pend;
  logic [ADDR_WIDTH-1:0]   pend_idx;
  logic                    best_hit;
  logic [COLOR_WIDTH-1:0]  best_color;
  logic [ADDR_WIDTH-1:0]   best_index;

  logic [ADDR_WIDTH:0]     cnt_in;
  logic                    last_issue;
  logic                    in_left, in_top, in_right, in_bottom, hit;

  assign cnt_in     = (rect_count > MAX_CNT) ? MAX_CNT : rect_count;
  assign last_issue = ({1'b0, idx} == (cnt - ONE));

  // Left/top edges inclusive, right/bottom exclusive; degenerate rects fail one side.
  comparator #(.WIDTH(COORD_WIDTH), .INCLUSIVE(1'b1)) u_cmp_left (
    .a(rect_left), .b(px), .res(in_left));
  comparator #(.WIDTH(COORD_WIDTH), .INCLUSIVE(1'b1)) u_cmp_top (
    .a(rect_top), .b(py), .res(in_top));
  comparator #(.WIDTH(COORD_WIDTH), .INCLUSIVE(1'b0)) u_cmp_right (
    .a(px), .b(rect_right), .res(in_right));
  comparator #(.WIDTH(COORD_WIDTH), .INCLUSIVE(1'b0)) u_cmp_bottom (
    .a(py), .b(rect_bottom), .res(in_bottom));

  assign hit = pend && in_left && in_top && in_right && in_bottom;

  assign mem_addr   = idx;
  assign resp_hit   = best_hit;
  assign resp_color = best_color;
  assign resp_index = best_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      px         <= '0;
      py         <= '0;
      pend       <= 1'b0;
      pend_idx   <= '0;
      best_hit   <= 1'b0;
      best_color <= '0;
      best_index <= '0;
      mem_rd_en  <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      // Read data returns one cycle after issue, so the compare tag trails the read by one edge.
      pend     <= mem_rd_en;
      pend_idx <= idx;

      if (hit) begin
        best_hit   <= 1'b1;
        best_color <= rect_color;
        best_index <= pend_idx;
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            px         <= req_x;
            py         <= req_y;
            cnt        <= cnt_in;
            idx        <= '0;
            best_hit   <= 1'b0;
            best_color <= bg_color;
            best_index <= '0;
            req_ready  <= 1'b0;
            if (cnt_in == '0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state     <= SCAN;
              mem_rd_en <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (last_issue) begin
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_hit_scanner.sv
// Self-checking bench for rect_hit_scanner: directed vector table, corner sequences, random vs reference model.

module tb_rect_hit_scanner;

  localparam int CW = 16;
  localparam int KW = 16;
  localparam int NR = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [CW-1:0] req_x, req_y;
  logic [AW:0]   rect_count;
  logic [KW-1:0] bg_color;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] rect_left, rect_top, rect_right, rect_bottom;
  logic [KW-1:0] rect_color;
  logic          resp_valid, resp_ready, resp_hit;
  logic [KW-1:0] resp_color;
  logic [AW-1:0] resp_index;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] rl [NR], rt [NR], rr [NR], rb [NR];
  logic [KW-1:0] rc [NR];
  int            rdc [NR];
  int            total_rd = 0;

  always #5 clk = ~clk;

  rect_hit_scanner #(.COORD_WIDTH(CW), .COLOR_WIDTH(KW), .MAX_RECTS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .rect_count(rect_count), .bg_color(bg_color),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .rect_left(rect_left), .rect_top(rect_top), .rect_right(rect_right),
    .rect_bottom(rect_bottom), .rect_color(rect_color),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_color(resp_color), .resp_index(resp_index)
  );

  // Registered-read rect memory; drives junk when no read was issued.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      rect_left   <= rl[mem_addr];
      rect_top    <= rt[mem_addr];
      rect_right  <= rr[mem_addr];
      rect_bottom <= rb[mem_addr];
      rect_color  <= rc[mem_addr];
      rdc[mem_addr] <= rdc[mem_addr] + 1;
      total_rd    <= total_rd + 1;
    end else begin
      rect_left   <= 16'($urandom);
      rect_top    <= 16'($urandom);
      rect_right  <= 16'($urandom);
      rect_bottom <= 16'($urandom);
      rect_color  <= 16'($urandom);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the highest-index rect among the first min(count,64) that covers the pixel.
  function automatic void model(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                input int c, input logic [KW-1:0] bg,
                                output logic h, output logic [KW-1:0] col,
                                output logic [AW-1:0] ix, output int lat);
    int n;
    n   = (c > NR) ? NR : c;
    h   = 1'b0;
    col = bg;
    ix  = '0;
    for (int i = 0; i < n; i++)
      if (rl[i] <= x && x < rr[i] && rt[i] <= y && y < rb[i]) begin
        h   = 1'b1;
        col = rc[i];
        ix  = AW'(i);
      end
    lat = (n == 0) ? 1 : n + 2;
  endfunction

  task automatic do_req(input logic [CW-1:0] x, input logic [CW-1:0] y, input int c,
                        input logic [KW-1:0] bg, input int hold,
                        output logic h, output logic [KW-1:0] col,
                        output logic [AW-1:0] ix, output int lat);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_x = x; req_y = y; rect_count = (AW+1)'(c); bg_color = bg; req_valid = 1'b1;
    @(posedge clk);
    #1;
    // Junk on the request bus while busy must be ignored.
    req_x = 16'($urandom); req_y = 16'($urandom);
    rect_count = 7'($urandom); bg_color = 16'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!resp_valid) chk("req_ready_busy", req_ready, 0);
    end while (!resp_valid && lat < 400);
    req_valid = 1'b0;
    if (!resp_valid) chk("resp_timeout", resp_valid, 1);
    h = resp_hit; col = resp_color; ix = resp_index;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("resp_stable", {resp_valid, req_ready, resp_hit, resp_color, resp_index},
          {1'b1, 1'b0, h, col, ix});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_hs", {req_ready, resp_valid}, 2'b10);
  endtask

  typedef struct {
    logic [CW-1:0] x, y;
    int            cnt;
    logic [KW-1:0] bg;
    int            hold;
    logic          hit;
    logic [KW-1:0] color;
    logic [AW-1:0] idx;
    int            lat;
  } vec_t;

  localparam logic [KW-1:0] RED = 16'hF800, GREEN = 16'h07E0, BLUE = 16'h001F, BG = 16'hAAAA;

  vec_t          vecs [11];
  logic          h;
  logic [KW-1:0] col;
  logic [AW-1:0] ix;
  int            lat, rd0, seen, bad;
  int            base [NR];
  logic          eh;
  logic [KW-1:0] ecol;
  logic [AW-1:0] eix;
  int            elat, ec;

  task automatic load_basic();
    for (int i = 0; i < NR; i++) begin
      rl[i] = 16'd500; rt[i] = 16'd500; rr[i] = 16'd400; rb[i] = 16'd400; rc[i] = 16'(i);
    end
    rl[0] = 0;  rt[0] = 0;  rr[0] = 10; rb[0] = 10; rc[0] = RED;
    rl[1] = 5;  rt[1] = 5;  rr[1] = 20; rb[1] = 20; rc[1] = GREEN;
    rl[2] = 30; rt[2] = 30; rr[2] = 40; rb[2] = 40; rc[2] = BLUE;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rdc[i] = 0;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_x = '0; req_y = '0; rect_count = '0; bg_color = '0;
    load_basic();

    vecs[0]  = '{7,  7,  3, BG,       0, 1'b1, GREEN,    6'd1, 5};
    vecs[1]  = '{10, 3,  3, BG,       0, 1'b0, BG,       6'd0, 5};
    vecs[2]  = '{5,  5,  3, BG,       0, 1'b1, GREEN,    6'd1, 5};
    vecs[3]  = '{20, 20, 3, BG,       0, 1'b0, BG,       6'd0, 5};
    vecs[4]  = '{35, 35, 3, BG,       4, 1'b1, BLUE,     6'd2, 5};
    vecs[5]  = '{9,  9,  3, BG,       0, 1'b1, GREEN,    6'd1, 5};
    vecs[6]  = '{0,  0,  3, BG,       0, 1'b1, RED,      6'd0, 5};
    vecs[7]  = '{9,  9,  1, BG,       0, 1'b1, RED,      6'd0, 3};
    vecs[8]  = '{7,  7,  0, 16'h1234, 0, 1'b0, 16'h1234, 6'd0, 1};
    vecs[9]  = '{39, 39, 3, BG,       2, 1'b1, BLUE,     6'd2, 5};
    vecs[10] = '{40, 40, 3, BG,       0, 1'b0, BG,       6'd0, 5};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outputs", {req_ready, resp_valid, mem_rd_en, resp_hit, resp_color, resp_index, mem_addr},
        {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 6'h0, 6'h0});
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {req_ready, resp_valid, mem_rd_en}, 3'b100);

    // Directed vector table
    foreach (vecs[v]) begin
      rd0 = total_rd;
      do_req(vecs[v].x, vecs[v].y, vecs[v].cnt, vecs[v].bg, vecs[v].hold, h, col, ix, lat);
      chk($sformatf("vec%0d_hit", v), h, vecs[v].hit);
      chk($sformatf("vec%0d_color", v), col, vecs[v].color);
      chk($sformatf("vec%0d_index", v), ix, vecs[v].idx);
      chk($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("vec%0d_reads", v), total_rd - rd0, vecs[v].cnt);
    end

    // Oversized count: only rect 63 covers, every address read exactly once
    for (int i = 0; i < NR - 1; i++) begin
      rl[i] = 0; rt[i] = 0; rr[i] = 10; rb[i] = 10; rc[i] = 16'(i);
    end
    rl[63] = 90; rt[63] = 90; rr[63] = 110; rb[63] = 110; rc[63] = 16'hBEEF;
    for (int i = 0; i < NR; i++) base[i] = rdc[i];
    rd0 = total_rd;
    do_req(100, 100, NR + 5, BG, 0, h, col, ix, lat);
    chk("clamp_result", {h, col, ix}, {1'b1, 16'hBEEF, 6'd63});
    chk("clamp_latency", lat, NR + 2);
    chk("clamp_reads", total_rd - rd0, NR);
    bad = 0;
    for (int i = 0; i < NR; i++) if (rdc[i] - base[i] != 1) bad++;
    chk("clamp_addr_once", bad, 0);

    // Reset pulsed while the third read is being issued
    load_basic();
    @(negedge clk);
    req_x = 7; req_y = 7; rect_count = 3; bg_color = BG; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !(mem_rd_en && mem_addr == 2); k++) @(negedge clk);
    chk("rst_scan_reached_idx2", {mem_rd_en, mem_addr}, {1'b1, 6'd2});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {req_ready, resp_valid, mem_rd_en, resp_hit, resp_color, resp_index},
        {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 6'h0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_valid || mem_rd_en) seen++;
    end
    chk("rst_no_resp", seen, 0);
    do_req(7, 7, 3, BG, 1, h, col, ix, lat);
    chk("rst_fresh_result", {h, col, ix}, {1'b1, GREEN, 6'd1});
    chk("rst_fresh_latency", lat, 5);

    // Random tables and requests vs reference model
    for (int t = 0; t < 40; t++) begin
      if (t % 10 == 0)
        for (int i = 0; i < NR; i++) begin
          rl[i] = 16'($urandom_range(0, 50));
          rt[i] = 16'($urandom_range(0, 50));
          rr[i] = 16'($urandom_range(0, 70));
          rb[i] = 16'($urandom_range(0, 70));
          rc[i] = 16'($urandom);
        end
      ec = $urandom_range(0, 75);
      req_x = 16'($urandom_range(0, 72));
      req_y = 16'($urandom_range(0, 72));
      bg_color = 16'($urandom);
      model(req_x, req_y, ec, bg_color, eh, ecol, eix, elat);
      do_req(req_x, req_y, ec, bg_color, $urandom_range(0, 2), h, col, ix, lat);
      chk($sformatf("rand%0d_result", t), {h, col, ix}, {eh, ecol, eix});
      chk($sformatf("rand%0d_latency", t), lat, elat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
